// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson sequencer: seven-segment glyphs,
// index-width helper and the per-cycle update operation.
package johnson_pkg;

  // Active-low glyphs, bit 6 = segment a ... bit 0 = segment g.
  localparam logic [6:0] SEG_GLYPH [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic [1:0] {
    OP_HOLD    = 2'd0,
    OP_FWD     = 2'd1,
    OP_REV     = 2'd2,
    OP_RECOVER = 2'd3
  } jc_op_e;

  function automatic int idx_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex digit to active-low seven-segment pattern.
module hex7seg
  import johnson_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[hex];

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Johnson counter sequencer with prescaled free-run, single-step advance,
// position index, hex display and a sticky illegal-state recovery.
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DIV_W = 25,
  localparam int IW    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             step,
  input  logic [DIV_W-1:0] div_max,
  input  logic             clr_err,
  output logic [WIDTH-1:0] jc,
  output logic [IW-1:0]    idx,
  output logic [6:0]       seg,
  output logic             wrap,
  output logic             err
);

  localparam logic [IW-1:0] LAST = IW'(2 * WIDTH - 1);

  logic [DIV_W-1:0] cnt;
  logic [WIDTH-1:0] jc_q;
  logic             tick;
  logic             legal;
  logic             bad;
  logic [WIDTH-1:0] expect_code;
  jc_op_e           op;

  // Johnson code at position pos: pos ones filling from the LSB, then
  // zeros filling from the LSB once all bits are set.
  function automatic logic [WIDTH-1:0] code_for(input int pos);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (pos < WIDTH) begin
      return ~(ones << pos);
    end else begin
      return ones << (pos - WIDTH);
    end
  endfunction

  assign jc   = jc_q;
  assign tick = en && (cnt == div_max);

  // Prescaler: holds when disabled, wraps at or above the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= cnt;
    end else if (cnt >= div_max) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Legality check runs on the driven output so the whole jc path is covered.
  always_comb begin
    legal = 1'b0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      legal = legal | (jc == code_for(i));
    end
    expect_code = code_for(int'(idx));
    bad = !legal || (jc != expect_code) || (idx > LAST);
  end

  // Recovery outranks any advance; tick and step merge into a single advance.
  always_comb begin
    op = OP_HOLD;
    if (bad) begin
      op = OP_RECOVER;
    end else if (tick || step) begin
      op = dir ? OP_REV : OP_FWD;
    end else begin
      op = OP_HOLD;
    end
  end

  // Counter state, index and wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jc_q <= '0;
      idx  <= '0;
      wrap <= 1'b0;
    end else begin
      case (op)
        OP_RECOVER: begin
          jc_q <= '0;
          idx  <= '0;
          wrap <= 1'b0;
        end
        OP_FWD: begin
          jc_q <= {jc_q[WIDTH-2:0], ~jc_q[WIDTH-1]};
          idx  <= (idx == LAST) ? '0 : idx + IW'(1);
          wrap <= (idx == LAST);
        end
        OP_REV: begin
          jc_q <= {~jc_q[0], jc_q[WIDTH-1:1]};
          idx  <= (idx == '0) ? LAST : idx - IW'(1);
          wrap <= (idx == '0);
        end
        default: begin
          jc_q <= jc_q;
          idx  <= idx;
          wrap <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error: a fresh detection wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (bad) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end else begin
      err <= err;
    end
  end

  hex7seg u_hex7seg (
    .hex (4'(idx)),
    .seg (seg)
  );

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Randomized and directed bench for johnson_seq_ctrl (WIDTH=4 and WIDTH=8).
module tb_johnson_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, en4, dir4, step4, clr4;
  logic [24:0] dm4;
  logic [3:0]  jc4;
  logic [2:0]  idx4;
  logic [6:0]  seg4;
  logic        wrap4, err4;

  logic        rst8, en8, dir8, step8, clr8;
  logic [24:0] dm8;
  logic [7:0]  jc8;
  logic [3:0]  idx8;
  logic [6:0]  seg8;
  logic        wrap8, err8;

  johnson_seq_ctrl #(.WIDTH(4), .DIV_W(25)) u4 (
    .clk(clk), .rst(rst4), .en(en4), .dir(dir4), .step(step4), .div_max(dm4),
    .clr_err(clr4), .jc(jc4), .idx(idx4), .seg(seg4), .wrap(wrap4), .err(err4)
  );

  johnson_seq_ctrl #(.WIDTH(8), .DIV_W(25)) u8 (
    .clk(clk), .rst(rst8), .en(en8), .dir(dir8), .step(step8), .div_max(dm8),
    .clr_err(clr8), .jc(jc8), .idx(idx8), .seg(seg8), .wrap(wrap8), .err(err8)
  );

  localparam logic [6:0] GLYPH [0:15] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state for the WIDTH=4 instance.
  int m_cnt, m_idx, m_err, m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Johnson pattern for position p of a w-bit counter, by plain arithmetic.
  function automatic int jcode(input int w, input int p);
    int full;
    full = (1 << w) - 1;
    if (p < w) return (1 << p) - 1;
    else       return (full << (p - w)) & full;
  endfunction

  task automatic check4();
    check("jc4",   jc4,   jcode(4, m_idx));
    check("idx4",  idx4,  m_idx);
    check("wrap4", wrap4, m_wrap);
    check("err4",  err4,  m_err);
    check("seg4",  seg4,  GLYPH[m_idx]);
  endtask

  // One clock of the WIDTH=4 instance with the inputs currently applied.
  task automatic tick4(input bit force_bad);
    bit tk, adv;
    tk = en4 && (m_cnt == int'(dm4));
    if (en4) m_cnt = (m_cnt >= int'(dm4)) ? 0 : m_cnt + 1;
    adv = tk || step4;
    m_wrap = 0;
    if (force_bad) begin
      m_idx = 0;
      m_err = 1;
    end else begin
      if (adv && !dir4) begin
        m_wrap = (m_idx == 7);
        m_idx  = (m_idx + 1) % 8;
      end else if (adv) begin
        m_wrap = (m_idx == 0);
        m_idx  = (m_idx + 7) % 8;
      end
      if (clr4) m_err = 0;
    end
    if (force_bad) force u4.jc = 4'b0101;
    @(posedge clk);
    #1;
    if (force_bad) begin
      release u4.jc;
      #1;
    end
    check4();
  endtask

  task automatic reset4_pulse();
    #2 rst4 = 1'b1;
    #1;
    check("rst_jc",   jc4,   4'b0000);
    check("rst_idx",  idx4,  3'd0);
    check("rst_seg",  seg4,  7'b0000001);
    check("rst_wrap", wrap4, 1'b0);
    check("rst_err",  err4,  1'b0);
    @(posedge clk);
    #1;
    rst4  = 1'b0;
    step4 = 1'b0;
    m_cnt = 0; m_idx = 0; m_err = 0; m_wrap = 0;
  endtask

  initial begin
    logic [3:0] rev_exp [0:3];
    int prev, k, e;
    rev_exp[0] = 4'b0011; rev_exp[1] = 4'b0001;
    rev_exp[2] = 4'b0000; rev_exp[3] = 4'b1000;

    rst4 = 1'b1; en4 = 1'b0; dir4 = 1'b0; step4 = 1'b0; clr4 = 1'b0; dm4 = 25'd2;
    rst8 = 1'b1; en8 = 1'b0; dir8 = 1'b0; step8 = 1'b0; clr8 = 1'b0; dm8 = 25'd0;
    m_cnt = 0; m_idx = 0; m_err = 0; m_wrap = 0;
    @(posedge clk); @(posedge clk); #1;
    check4();
    rst4 = 1'b0; rst8 = 1'b0;

    // Free run forward, period 3, through more than one wrap.
    en4 = 1'b1;
    for (int i = 0; i < 30; i++) tick4(1'b0);

    // Single steps to idx 3, then reverse steps across the wrap.
    en4 = 1'b0;
    for (int i = 0; i < 10 && m_idx != 3; i++) begin
      step4 = 1'b1; tick4(1'b0); step4 = 1'b0; tick4(1'b0);
    end
    check("at_idx3", idx4, 3'd3);
    dir4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step4 = 1'b1; tick4(1'b0); step4 = 1'b0;
      check("rev_jc", jc4, rev_exp[i]);
      check("rev_wrap", wrap4, (i == 3) ? 1'b1 : 1'b0);
      tick4(1'b0);
    end
    dir4 = 1'b0;

    // Step coincident with a tick gives exactly one advance.
    dm4 = 25'd0;
    tick4(1'b0); tick4(1'b0);
    prev = m_idx;
    en4 = 1'b1; step4 = 1'b1;
    tick4(1'b0);
    check("tick_step_once", idx4, (prev + 1) % 8);
    step4 = 1'b0; en4 = 1'b0;
    tick4(1'b0);

    // Illegal state recovery, clear, and clear colliding with detection.
    dm4 = 25'd2; en4 = 1'b1;
    for (int i = 0; i < 5; i++) tick4(1'b0);
    tick4(1'b1);
    check("recover_err", err4, 1'b1);
    tick4(1'b0);
    clr4 = 1'b1; tick4(1'b0); clr4 = 1'b0;
    check("clr_err", err4, 1'b0);
    for (int i = 0; i < 4; i++) tick4(1'b0);
    clr4 = 1'b1; tick4(1'b1); clr4 = 1'b0;
    check("clr_vs_detect", err4, 1'b1);
    clr4 = 1'b1; tick4(1'b0); clr4 = 1'b0;

    // Reset mid period at idx 5, then measure the first advance.
    dm4 = 25'd2; en4 = 1'b1; dir4 = 1'b0;
    for (int i = 0; i < 100 && m_idx != 5; i++) tick4(1'b0);
    check("at_idx5", idx4, 3'd5);
    tick4(1'b0);
    reset4_pulse();
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      tick4(1'b0);
      if (idx4 != 3'd0) k = i;
    end
    check("post_reset_latency", k, 3);

    // Randomized mix of enable, direction, steps, clears, periods and faults.
    for (int i = 0; i < 3000; i++) begin
      en4   = ($urandom_range(0, 9) != 0);
      step4 = ($urandom_range(0, 5) == 0);
      clr4  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) dir4 = ~dir4;
      if ($urandom_range(0, 39) == 0) dm4 = 25'($urandom_range(0, 5));
      tick4($urandom_range(0, 199) == 0);
    end
    step4 = 1'b0; clr4 = 1'b0;

    // WIDTH=8 free run at full rate.
    #2 rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0; en8 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      e = i % 16;
      check("jc8",   jc8,   jcode(8, e));
      check("idx8",  idx8,  e);
      check("seg8",  seg8,  GLYPH[e]);
      check("wrap8", wrap8, (e == 0) ? 1'b1 : 1'b0);
      check("err8",  err8,  1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
